// File: rtl/ex_stage_pkg.sv
// Shared types and encodings for the RV32I execute stage.
// data_t/addr_t are the common 32-bit datapath types. alu_op_t, fwd_sel_t and
// result_src_t name the control encodings driven by decode and hazard logic.
// The F3_* constants give the branch conditions carried in funct3.
package ex_stage_pkg;

    typedef logic [31:0] data_t;
    typedef logic [31:0] addr_t;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_SLTU   = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,
        FWD_WB      = 2'b01,
        FWD_MEM     = 2'b10,
        FWD_REG_ALT = 2'b11
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RES_ALU  = 2'd0,
        RES_MEM  = 2'd1,
        RES_PC4  = 2'd2,
        RES_RSVD = 2'd3
    } result_src_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU plus branch comparator for the execute stage.
// Ports: a, b      - ALU operands (already muxed for pc/imm)
//        op        - alu_op_t encoding; unused codes yield 0
//        cmp_a/b   - forwarded rs1/rs2 for the branch compare
//        funct3    - branch condition select
//        result    - ALU result (wraps modulo 2^32)
//        taken     - branch condition outcome
module ex_alu
    import ex_stage_pkg::*;
(
    input  data_t      a,
    input  data_t      b,
    input  logic [3:0] op,
    input  data_t      cmp_a,
    input  data_t      cmp_b,
    input  logic [2:0] funct3,
    output data_t      result,
    output logic       taken
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (alu_op_t'(op))
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_AND:    result = a & b;
            ALU_OR:     result = a | b;
            ALU_XOR:    result = a ^ b;
            ALU_SLL:    result = a << shamt;
            ALU_SRL:    result = a >> shamt;
            ALU_SRA:    result = data_t'($signed(a) >>> shamt);
            ALU_SLT:    result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU:   result = {31'd0, a < b};
            ALU_PASS_B: result = b;
            default:    result = '0;
        endcase
    end

    // funct3 010/011 are not branch conditions and never resolve taken.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (cmp_a == cmp_b);
            F3_BNE:  taken = (cmp_a != cmp_b);
            F3_BLT:  taken = ($signed(cmp_a) <  $signed(cmp_b));
            F3_BGE:  taken = ($signed(cmp_a) >= $signed(cmp_b));
            F3_BLTU: taken = (cmp_a <  cmp_b);
            F3_BGEU: taken = (cmp_a >= cmp_b);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage RV32I pipeline.
// Inputs : ID/EX slot (id_*), forwarding selects and wb_result, stall/flush.
// Outputs: EX/MEM register (mem_*), and the combinational PC redirect
//          (pc_redirect, pc_target) for taken branches and jumps.
// EX/MEM priority: reset > stall > flush > load.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_pc_plus4,
    input  logic [3:0]      id_alu_op,
    input  logic            id_alu_src_a,
    input  logic            id_alu_src_b,
    input  logic [2:0]      id_funct3,
    input  logic            id_branch,
    input  logic            id_jump,
    input  logic            id_jalr,
    input  logic            id_reg_write,
    input  logic            id_mem_write,
    input  logic [1:0]      id_result_src,
    input  logic [1:0]      fwd_a_sel,
    input  logic [1:0]      fwd_b_sel,
    input  logic [XLEN-1:0] wb_result,
    output logic            mem_valid,
    output logic            mem_reg_write,
    output logic            mem_mem_write,
    output logic [1:0]      mem_result_src,
    output logic [2:0]      mem_funct3,
    output logic [4:0]      mem_rd,
    output logic [XLEN-1:0] mem_alu_result,
    output logic [XLEN-1:0] mem_write_data,
    output logic [XLEN-1:0] mem_pc_plus4,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_target
);

    data_t fwd_a, fwd_b;
    data_t alu_a, alu_b, alu_result;
    data_t jalr_sum;
    logic  taken;

    // Source 10 feeds back this stage's own EX/MEM result.
    always_comb begin
        fwd_a = id_rs1_data;
        case (fwd_sel_t'(fwd_a_sel))
            FWD_WB:  fwd_a = wb_result;
            FWD_MEM: fwd_a = mem_alu_result;
            default: fwd_a = id_rs1_data;
        endcase
    end

    always_comb begin
        fwd_b = id_rs2_data;
        case (fwd_sel_t'(fwd_b_sel))
            FWD_WB:  fwd_b = wb_result;
            FWD_MEM: fwd_b = mem_alu_result;
            default: fwd_b = id_rs2_data;
        endcase
    end

    assign alu_a = id_alu_src_a ? id_pc  : fwd_a;
    assign alu_b = id_alu_src_b ? id_imm : fwd_b;

    ex_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (id_alu_op),
        .cmp_a  (fwd_a),
        .cmp_b  (fwd_b),
        .funct3 (id_funct3),
        .result (alu_result),
        .taken  (taken)
    );

    assign jalr_sum    = fwd_a + id_imm;
    assign pc_target   = id_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : id_pc + id_imm;
    // Gated by reset so no redirect escapes while the pipeline is being cleared.
    assign pc_redirect = reset & id_valid & ~stall_e & (id_jump | (id_branch & taken));

    always_ff @(posedge clk) begin
        if (!reset || (!stall_e && flush_e)) begin
            mem_valid      <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_result_src <= '0;
            mem_funct3     <= '0;
            mem_rd         <= '0;
            mem_alu_result <= '0;
            mem_write_data <= '0;
            mem_pc_plus4   <= '0;
        end else if (!stall_e) begin
            mem_valid      <= id_valid;
            mem_reg_write  <= id_valid & id_reg_write;
            mem_mem_write  <= id_valid & id_mem_write;
            mem_result_src <= id_result_src;
            mem_funct3     <= id_funct3;
            mem_rd         <= id_rd;
            mem_alu_result <= alu_result;
            mem_write_data <= fwd_b;
            mem_pc_plus4   <= id_pc_plus4;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected EX/MEM contents are queued when each
// instruction is driven and compared one cycle later; redirect outputs are
// checked combinationally before the capturing edge.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall_e, flush_e, id_valid;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc, id_pc_plus4, wb_result;
    logic [4:0]  id_rd;
    logic [3:0]  id_alu_op;
    logic        id_alu_src_a, id_alu_src_b;
    logic [2:0]  id_funct3;
    logic        id_branch, id_jump, id_jalr, id_reg_write, id_mem_write;
    logic [1:0]  id_result_src, fwd_a_sel, fwd_b_sel;
    logic        mem_valid, mem_reg_write, mem_mem_write;
    logic [1:0]  mem_result_src;
    logic [2:0]  mem_funct3;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu_result, mem_write_data, mem_pc_plus4;
    logic        pc_redirect;
    logic [31:0] pc_target;

    int unsigned passed = 0;
    int unsigned total  = 0;

    typedef struct {
        logic        valid, rw, mw;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu, wd, pc4;
    } exp_t;

    exp_t sb[$];

    ex_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
        .id_valid(id_valid), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rd(id_rd), .id_imm(id_imm), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
        .id_alu_op(id_alu_op), .id_alu_src_a(id_alu_src_a), .id_alu_src_b(id_alu_src_b),
        .id_funct3(id_funct3), .id_branch(id_branch), .id_jump(id_jump), .id_jalr(id_jalr),
        .id_reg_write(id_reg_write), .id_mem_write(id_mem_write),
        .id_result_src(id_result_src), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .wb_result(wb_result), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_mem_write(mem_mem_write), .mem_result_src(mem_result_src),
        .mem_funct3(mem_funct3), .mem_rd(mem_rd), .mem_alu_result(mem_alu_result),
        .mem_write_data(mem_write_data), .mem_pc_plus4(mem_pc_plus4),
        .pc_redirect(pc_redirect), .pc_target(pc_target)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic push(input logic v, rw, mw, input logic [1:0] rs, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [31:0] alu, wd, pc4);
        exp_t e;
        e.valid = v; e.rw = rw; e.mw = mw; e.rs = rs; e.f3 = f3;
        e.rd = rd; e.alu = alu; e.wd = wd; e.pc4 = pc4;
        sb.push_back(e);
    endtask

    task automatic push_zero();
        push(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    endtask

    // Advance one cycle and compare EX/MEM against the oldest queued entry.
    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".valid"}, {31'd0, mem_valid},     {31'd0, e.valid});
            chk({tag, ".rw"},    {31'd0, mem_reg_write}, {31'd0, e.rw});
            chk({tag, ".mw"},    {31'd0, mem_mem_write}, {31'd0, e.mw});
            chk({tag, ".rs"},    {30'd0, mem_result_src}, {30'd0, e.rs});
            chk({tag, ".f3"},    {29'd0, mem_funct3},    {29'd0, e.f3});
            chk({tag, ".rd"},    {27'd0, mem_rd},        {27'd0, e.rd});
            chk({tag, ".alu"},   mem_alu_result,         e.alu);
            chk({tag, ".wd"},    mem_write_data,         e.wd);
            chk({tag, ".pc4"},   mem_pc_plus4,           e.pc4);
        end
    endtask

    task automatic clear();
        stall_e = 0; flush_e = 0; id_valid = 1;
        id_rs1_data = 0; id_rs2_data = 0; id_rd = 0; id_imm = 0;
        id_pc = 0; id_pc_plus4 = 0; id_alu_op = 0;
        id_alu_src_a = 0; id_alu_src_b = 0; id_funct3 = 0;
        id_branch = 0; id_jump = 0; id_jalr = 0;
        id_reg_write = 0; id_mem_write = 0; id_result_src = 0;
        fwd_a_sel = 0; fwd_b_sel = 0; wb_result = 0;
    endtask

    initial begin
        // Reset held for two cycles with a valid jump pending.
        clear();
        reset = 0; id_jump = 1; id_reg_write = 1; id_rs1_data = 32'h55;
        #1;
        chk("rst_redirect", {31'd0, pc_redirect}, 32'd0);
        push_zero(); tick("rst0");
        push_zero(); tick("rst1");
        chk("rst_redirect2", {31'd0, pc_redirect}, 32'd0);

        // ADDI x5 = 3 + 4
        reset = 1; clear();
        id_rs1_data = 3; id_rs2_data = 32'h55; id_imm = 4; id_alu_src_b = 1;
        id_reg_write = 1; id_rd = 5; id_pc_plus4 = 8;
        #1 chk("addi_redirect", {31'd0, pc_redirect}, 32'd0);
        push(1, 1, 0, 2'd0, 3'd0, 5'd5, 32'd7, 32'h55, 32'd8);
        tick("addi");

        // ADDI forwarding from EX/MEM (7 + 1)
        id_rs1_data = 100; id_imm = 1; fwd_a_sel = 2'b10;
        push(1, 1, 0, 2'd0, 3'd0, 5'd5, 32'd8, 32'h55, 32'd8);
        tick("fwd_mem");

        // ADDI forwarding from WB (0x10 + 1); store data forwarded from EX/MEM (8)
        fwd_a_sel = 2'b01; wb_result = 32'h10; fwd_b_sel = 2'b10;
        push(1, 1, 0, 2'd0, 3'd0, 5'd5, 32'h11, 32'd8, 32'd8);
        tick("fwd_wb");

        // SRA with fwd select 11 (register path); shift amount is B[4:0]=1
        clear();
        fwd_a_sel = 2'b11; fwd_b_sel = 2'b11; wb_result = 32'hDEAD;
        id_rs1_data = 32'h8000_0000; id_rs2_data = 32'h21; id_alu_op = 4'd7;
        id_reg_write = 1; id_rd = 6; id_pc_plus4 = 32'h20;
        push(1, 1, 0, 2'd0, 3'd0, 5'd6, 32'hC000_0000, 32'h21, 32'h20);
        tick("sra");
        id_alu_op = 4'd6;
        push(1, 1, 0, 2'd0, 3'd0, 5'd6, 32'h4000_0000, 32'h21, 32'h20);
        tick("srl");

        // BLT -1 < 1 : taken
        clear();
        id_rs1_data = 32'hFFFF_FFFF; id_rs2_data = 1; id_pc = 32'h100; id_imm = 32'h20;
        id_pc_plus4 = 32'h104; id_branch = 1; id_funct3 = 3'b100; id_alu_op = 4'd8;
        #1;
        chk("blt_redirect", {31'd0, pc_redirect}, 32'd1);
        chk("blt_target", pc_target, 32'h120);
        push(1, 0, 0, 2'd0, 3'b100, 5'd0, 32'd1, 32'd1, 32'h104);
        tick("blt");

        // BLTU 0xFFFFFFFF < 1 : not taken
        id_funct3 = 3'b110; id_alu_op = 4'd9;
        #1;
        chk("bltu_redirect", {31'd0, pc_redirect}, 32'd0);
        chk("bltu_target", pc_target, 32'h120);
        push(1, 0, 0, 2'd0, 3'b110, 5'd0, 32'd0, 32'd1, 32'h104);
        tick("bltu");

        // funct3 010 never taken; PASS_B of rs2
        id_funct3 = 3'b010; id_alu_op = 4'd10;
        #1 chk("f3_010_redirect", {31'd0, pc_redirect}, 32'd0);
        push(1, 0, 0, 2'd0, 3'b010, 5'd0, 32'd1, 32'd1, 32'h104);
        tick("passb");

        // Unused op code yields zero
        id_branch = 0; id_alu_op = 4'd12; id_funct3 = 3'b000;
        push(1, 0, 0, 2'd0, 3'b000, 5'd0, 32'd0, 32'd1, 32'h104);
        tick("op12");

        // SUB wraps; store with valid slot
        clear();
        id_rs1_data = 5; id_rs2_data = 7; id_alu_op = 4'd1; id_mem_write = 1;
        id_funct3 = 3'b010; id_pc_plus4 = 32'h50;
        push(1, 0, 1, 2'd0, 3'b010, 5'd0, 32'hFFFF_FFFE, 32'd7, 32'h50);
        tick("sub_sw");

        // SLL / XOR
        clear();
        id_rs1_data = 1; id_rs2_data = 32'h23; id_alu_op = 4'd5; id_reg_write = 1; id_rd = 9;
        push(1, 1, 0, 2'd0, 3'd0, 5'd9, 32'd8, 32'h23, 32'd0);
        tick("sll");
        id_rs1_data = 32'hF0F0_F0F0; id_rs2_data = 32'hFF00_FF00; id_alu_op = 4'd4;
        push(1, 1, 0, 2'd0, 3'd0, 5'd9, 32'h0FF0_0FF0, 32'hFF00_FF00, 32'd0);
        tick("xor");

        // JALR: target (0x203 + 4) & ~1
        clear();
        id_jump = 1; id_jalr = 1; id_rs1_data = 32'h203; id_imm = 4; id_pc = 32'h40;
        id_pc_plus4 = 32'h44; id_reg_write = 1; id_result_src = 2'd2; id_rd = 1;
        id_alu_src_b = 1;
        #1;
        chk("jalr_target", pc_target, 32'h206);
        chk("jalr_redirect", {31'd0, pc_redirect}, 32'd1);
        push(1, 1, 0, 2'd2, 3'd0, 5'd1, 32'h207, 32'd0, 32'h44);
        tick("jalr");

        // Stall + flush together: hold, redirect suppressed on taken BEQ
        clear();
        stall_e = 1; flush_e = 1; id_branch = 1; id_rs1_data = 5; id_rs2_data = 5;
        id_pc = 32'h80; id_imm = 8; id_rd = 3; id_reg_write = 1;
        #1 chk("stall_redirect", {31'd0, pc_redirect}, 32'd0);
        push(1, 1, 0, 2'd2, 3'd0, 5'd1, 32'h207, 32'd0, 32'h44);
        tick("stall_flush");

        // Flush only: bubble, redirect still follows the taken branch
        stall_e = 0; id_mem_write = 1;
        #1;
        chk("flush_redirect", {31'd0, pc_redirect}, 32'd1);
        chk("flush_target", pc_target, 32'h88);
        push_zero();
        tick("flush");

        // Invalid slot: write enables gated, other fields captured
        clear();
        id_valid = 0; id_jump = 1; id_reg_write = 1; id_mem_write = 1; id_rd = 7;
        id_rs1_data = 1; id_rs2_data = 2; id_funct3 = 3'b010; id_pc_plus4 = 32'h64;
        #1 chk("invalid_redirect", {31'd0, pc_redirect}, 32'd0);
        push(0, 0, 0, 2'd0, 3'b010, 5'd7, 32'd3, 32'd2, 32'h64);
        tick("invalid");

        // Mid-stream reset discards EX/MEM and blocks the redirect
        clear();
        reset = 0; id_jump = 1; id_reg_write = 1; id_rd = 4;
        #1 chk("midrst_redirect", {31'd0, pc_redirect}, 32'd0);
        push_zero();
        tick("midrst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
